// File: rtl/pipe_scroller.sv
// pipe_scroller: horizontal positions of NUM_PIPES pipe obstacles, scrolled
// left once per tick, recycled to the right once they leave the screen.
// Also counts pipes passed by the bird and runs the INITIAL/COUNT/STOP FSM.
// Ports: clk, reset (async, active low); Start/Ack/Hit game handshake;
// Speed selects the step multiplier; X_Edge_L/X_Edge_R are packed pipe edges
// (pipe i at [i*X_W +: X_W]); Score is the saturating pass count;
// out_pipe/pipe_wrap report recycling; Q_Initial/Q_Count/Q_Stop one-hot state.
module pipe_scroller #(
    parameter int NUM_PIPES = 4,
    parameter int X_W       = 11,
    parameter int PIPE_W    = 60,
    parameter int SPACING   = 160,
    parameter int X_START   = 640,
    parameter int TICK_DIV  = 4,
    parameter int STEP      = 1,
    parameter int BIRD_X    = 100,
    parameter int SCORE_W   = 4,
    localparam int OP_W     = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     Start,
    input  logic                     Ack,
    input  logic                     Hit,
    input  logic [1:0]               Speed,
    output logic [NUM_PIPES*X_W-1:0] X_Edge_L,
    output logic [NUM_PIPES*X_W-1:0] X_Edge_R,
    output logic [SCORE_W-1:0]       Score,
    output logic [OP_W-1:0]          out_pipe,
    output logic                     pipe_wrap,
    output logic                     Q_Initial,
    output logic                     Q_Count,
    output logic                     Q_Stop
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SUM_W = SCORE_W + 4;
    localparam logic [X_W-1:0]   PW        = X_W'(PIPE_W);
    localparam logic [X_W-1:0]   BX        = X_W'(BIRD_X);
    localparam logic [X_W-1:0]   LOOP      = X_W'(NUM_PIPES * SPACING);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [SUM_W-1:0] SMAX      = SUM_W'((2 ** SCORE_W) - 1);

    typedef enum logic [1:0] {
        S_INIT,
        S_COUNT,
        S_STOP
    } state_t;

    state_t               state;
    logic [X_W-1:0]       r     [NUM_PIPES];
    logic [X_W-1:0]       r_nxt [NUM_PIPES];
    logic [CNT_W-1:0]     cnt;
    logic                 tick;
    logic [X_W-1:0]       s;
    logic [NUM_PIPES-1:0] wrap;
    logic [OP_W-1:0]      wrap_idx;
    logic [SUM_W-1:0]     passed;
    logic [SUM_W-1:0]     total;
    logic [SCORE_W-1:0]   score_nxt;

    function automatic logic [X_W-1:0] home(input int i);
        return X_W'(X_START + PIPE_W + i * SPACING);
    endfunction

    assign tick = (cnt == TICK_LAST);
    assign s    = X_W'(STEP) * (X_W'(Speed) + X_W'(1));

    // Next positions for a tick. A pipe that cannot take a full step wraps
    // by the ring length, which keeps the spacing exact across the wrap.
    always_comb begin
        passed   = '0;
        wrap     = '0;
        wrap_idx = '0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            if (r[i] > s) begin
                r_nxt[i] = r[i] - s;
                if ((r[i] >= BX) && (r_nxt[i] < BX)) begin
                    passed = passed + SUM_W'(1);
                end
            end else begin
                r_nxt[i] = r[i] - s + LOOP;
                wrap[i]  = 1'b1;
                wrap_idx = OP_W'(i);
            end
        end
        total     = SUM_W'(Score) + passed;
        score_nxt = (total > SMAX) ? SMAX[SCORE_W-1:0] : total[SCORE_W-1:0];
    end

    // Left edge clamps at 0 while a pipe is sliding off the left side.
    always_comb begin
        for (int i = 0; i < NUM_PIPES; i++) begin
            X_Edge_R[i*X_W +: X_W] = r[i];
            X_Edge_L[i*X_W +: X_W] = (r[i] >= PW) ? (r[i] - PW) : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_INIT;
            Q_Initial <= 1'b1;
            Q_Count   <= 1'b0;
            Q_Stop    <= 1'b0;
            cnt       <= '0;
            Score     <= '0;
            out_pipe  <= '0;
            pipe_wrap <= 1'b0;
            for (int i = 0; i < NUM_PIPES; i++) begin
                r[i] <= home(i);
            end
        end else begin
            pipe_wrap <= 1'b0;
            unique case (state)
                S_INIT: begin
                    cnt   <= '0;
                    Score <= '0;
                    for (int i = 0; i < NUM_PIPES; i++) begin
                        r[i] <= home(i);
                    end
                    if (Start) begin
                        state     <= S_COUNT;
                        Q_Initial <= 1'b0;
                        Q_Count   <= 1'b1;
                    end
                end
                S_COUNT: begin
                    // Hit pre-empts a coincident tick entirely.
                    if (Hit) begin
                        state   <= S_STOP;
                        Q_Count <= 1'b0;
                        Q_Stop  <= 1'b1;
                    end else if (tick) begin
                        cnt   <= '0;
                        Score <= score_nxt;
                        for (int i = 0; i < NUM_PIPES; i++) begin
                            r[i] <= r_nxt[i];
                        end
                        if (|wrap) begin
                            pipe_wrap <= 1'b1;
                            out_pipe  <= wrap_idx;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    // Reload happens on the way out so INITIAL is
                    // already clean in its first cycle.
                    if (Ack) begin
                        state     <= S_INIT;
                        Q_Stop    <= 1'b0;
                        Q_Initial <= 1'b1;
                        Score     <= '0;
                        for (int i = 0; i < NUM_PIPES; i++) begin
                            r[i] <= home(i);
                        end
                    end
                end
                default: begin
                    state     <= S_INIT;
                    Q_Initial <= 1'b1;
                    Q_Count   <= 1'b0;
                    Q_Stop    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_scroller.sv
// tb_pipe_scroller: self-checking bench for pipe_scroller, default and a
// small-spacing instance, against a rule-level model of the game.
module tb_pipe_scroller;

    localparam int XW = 11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start, ack, hit;
    logic [1:0] speed;
    logic       start2, ack2, hit2;
    logic [1:0] speed2;

    logic [4*XW-1:0] xl0, xr0, xl1, xr1;
    logic [3:0]      sc0, sc1;
    logic [1:0]      op0, op1;
    logic            pw0, pw1;
    logic            qi0, qc0, qs0, qi1, qc1, qs1;

    int n_vec = 0;
    int n_err = 0;

    pipe_scroller u0 (
        .clk(clk), .reset(reset), .Start(start), .Ack(ack), .Hit(hit),
        .Speed(speed), .X_Edge_L(xl0), .X_Edge_R(xr0), .Score(sc0),
        .out_pipe(op0), .pipe_wrap(pw0), .Q_Initial(qi0),
        .Q_Count(qc0), .Q_Stop(qs0)
    );

    pipe_scroller #(
        .PIPE_W(20), .SPACING(30), .X_START(100), .TICK_DIV(1)
    ) u1 (
        .clk(clk), .reset(reset), .Start(start2), .Ack(ack2), .Hit(hit2),
        .Speed(speed2), .X_Edge_L(xl1), .X_Edge_R(xr1), .Score(sc1),
        .out_pipe(op1), .pipe_wrap(pw1), .Q_Initial(qi1),
        .Q_Count(qc1), .Q_Stop(qs1)
    );

    logic [XW-1:0] r0 [4], l0 [4], r1 [4], l1 [4];
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            r0[i] = xr0[i*XW +: XW];
            l0[i] = xl0[i*XW +: XW];
            r1[i] = xr1[i*XW +: XW];
            l1[i] = xl1[i*XW +: XW];
        end
    end

    // Model configuration per instance.
    int c_np   [2] = '{4, 4};
    int c_pw   [2] = '{60, 20};
    int c_sp   [2] = '{160, 30};
    int c_xs   [2] = '{640, 100};
    int c_td   [2] = '{4, 1};
    int c_bx   [2] = '{100, 100};
    int c_smax [2] = '{15, 15};

    // Model state: mode 0=INITIAL 1=COUNT 2=STOP.
    int m_r     [2][4];
    int m_mode  [2];
    int m_score [2];
    int m_cyc   [2];
    int m_op    [2];
    bit m_wrap  [2];

    task automatic mreload(input int k);
        for (int i = 0; i < c_np[k]; i++)
            m_r[k][i] = c_xs[k] + c_pw[k] + i * c_sp[k];
    endtask

    task automatic mreset(input int k);
        m_mode[k] = 0; m_score[k] = 0; m_cyc[k] = 0;
        m_op[k] = 0; m_wrap[k] = 0;
        mreload(k);
    endtask

    task automatic mstep(input int k, input bit st, input bit ak,
                         input bit ht, input int spd);
        int s, nr, ns;
        m_wrap[k] = 0;
        if (m_mode[k] == 0) begin
            mreload(k);
            m_score[k] = 0;
            if (st) begin m_mode[k] = 1; m_cyc[k] = 0; end
        end else if (m_mode[k] == 1) begin
            if (ht) m_mode[k] = 2;
            else begin
                m_cyc[k]++;
                if (m_cyc[k] % c_td[k] == 0) begin
                    s = spd + 1;
                    ns = 0;
                    for (int i = 0; i < c_np[k]; i++) begin
                        if (m_r[k][i] > s) begin
                            nr = m_r[k][i] - s;
                            if (m_r[k][i] >= c_bx[k] && nr < c_bx[k]) ns++;
                        end else begin
                            nr = m_r[k][i] - s + c_np[k] * c_sp[k];
                            m_wrap[k] = 1;
                            m_op[k] = i;
                        end
                        m_r[k][i] = nr;
                    end
                    m_score[k] = m_score[k] + ns;
                    if (m_score[k] > c_smax[k]) m_score[k] = c_smax[k];
                end
            end
        end else begin
            if (ak) begin m_mode[k] = 0; m_score[k] = 0; mreload(k); end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        if (!reset) begin
            mreset(0);
            mreset(1);
        end else begin
            mstep(0, start, ack, hit, int'(speed));
            mstep(1, start2, ack2, hit2, int'(speed2));
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) cyc();
        n_vec += 8;
        if (qi0 !== 1'b1) begin n_err++; $display("FAIL rst_qi got %b want 1", qi0); end
        if ({qc0, qs0} !== 2'b00) begin n_err++; $display("FAIL rst_qcs got %b want 00", {qc0, qs0}); end
        if (r0[0] !== 11'd700) begin n_err++; $display("FAIL rst_r0 got %0d want 700", r0[0]); end
        if (l0[0] !== 11'd640) begin n_err++; $display("FAIL rst_l0 got %0d want 640", l0[0]); end
        if (r0[1] !== 11'd860) begin n_err++; $display("FAIL rst_r1 got %0d want 860", r0[1]); end
        if (r0[3] !== 11'd1180) begin n_err++; $display("FAIL rst_r3 got %0d want 1180", r0[3]); end
        if (sc0 !== 4'd0) begin n_err++; $display("FAIL rst_score got %0d want 0", sc0); end
        if ({pw0, op0} !== 3'b000) begin n_err++; $display("FAIL rst_wrap got %b want 000", {pw0, op0}); end
        reset = 1'b1;
    endtask

    task automatic test_scroll();
        speed = 2'd0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        n_vec++;
        if (qc0 !== 1'b1) begin n_err++; $display("FAIL scroll_qc got %b want 1", qc0); end
        repeat (3) cyc();
        n_vec++;
        if (r0[0] !== 11'd700) begin n_err++; $display("FAIL scroll_pre got %0d want 700", r0[0]); end
        cyc();
        n_vec++;
        if (r0[0] !== 11'd699) begin n_err++; $display("FAIL scroll_t1 got %0d want 699", r0[0]); end
        repeat (36) cyc();
        n_vec++;
        if (r0[0] !== 11'd690) begin n_err++; $display("FAIL scroll_t10 got %0d want 690", r0[0]); end
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (11'(r0[i+1] - r0[i]) !== 11'd160) begin
                n_err++;
                $display("FAIL scroll_gap%0d got %0d want 160", i, r0[i+1] - r0[i]);
            end
        end
    endtask

    task automatic test_score();
        repeat (2360) cyc();
        n_vec += 2;
        if (r0[0] !== 11'd100) begin n_err++; $display("FAIL score_t600 got %0d want 100", r0[0]); end
        if (sc0 !== 4'd0) begin n_err++; $display("FAIL score_pre got %0d want 0", sc0); end
        repeat (4) cyc();
        n_vec += 2;
        if (r0[0] !== 11'd99) begin n_err++; $display("FAIL score_t601 got %0d want 99", r0[0]); end
        if (sc0 !== 4'd1) begin n_err++; $display("FAIL score_one got %0d want 1", sc0); end
        repeat (396) cyc();
        n_vec += 5;
        if (pw0 !== 1'b1) begin n_err++; $display("FAIL wrap_pulse got %b want 1", pw0); end
        if (op0 !== 2'd0) begin n_err++; $display("FAIL wrap_idx got %0d want 0", op0); end
        if (r0[0] !== 11'd640) begin n_err++; $display("FAIL wrap_r0 got %0d want 640", r0[0]); end
        if (r0[3] !== 11'd480) begin n_err++; $display("FAIL wrap_r3 got %0d want 480", r0[3]); end
        if (sc0 !== 4'd1) begin n_err++; $display("FAIL wrap_score got %0d want 1", sc0); end
        cyc();
        n_vec++;
        if (pw0 !== 1'b0) begin n_err++; $display("FAIL wrap_drop got %b want 0", pw0); end
    endtask

    task automatic test_hit();
        repeat (2) cyc();
        hit = 1'b1;
        cyc();
        hit = 1'b0;
        n_vec += 2;
        if (qs0 !== 1'b1) begin n_err++; $display("FAIL hit_qs got %b want 1", qs0); end
        if (r0[0] !== 11'd640) begin n_err++; $display("FAIL hit_nomove got %0d want 640", r0[0]); end
        start = 1'b1;
        repeat (20) cyc();
        n_vec += 4;
        if (qs0 !== 1'b1) begin n_err++; $display("FAIL stop_hold got %b want 1", qs0); end
        if (r0[0] !== 11'd640) begin n_err++; $display("FAIL stop_r0 got %0d want 640", r0[0]); end
        if (r0[3] !== 11'd480) begin n_err++; $display("FAIL stop_r3 got %0d want 480", r0[3]); end
        if (sc0 !== 4'd1) begin n_err++; $display("FAIL stop_score got %0d want 1", sc0); end
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        n_vec += 3;
        if ({qi0, qc0, qs0} !== 3'b100) begin n_err++; $display("FAIL ack_state got %b want 100", {qi0, qc0, qs0}); end
        if (r0[0] !== 11'd700) begin n_err++; $display("FAIL ack_r0 got %0d want 700", r0[0]); end
        if (sc0 !== 4'd0) begin n_err++; $display("FAIL ack_score got %0d want 0", sc0); end
        cyc();
        start = 1'b0;
        n_vec++;
        if (qc0 !== 1'b1) begin n_err++; $display("FAIL restart_qc got %b want 1", qc0); end
    endtask

    task automatic test_speed();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        speed = 2'd3;
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (4) cyc();
        n_vec++;
        if (r0[0] !== 11'd696) begin n_err++; $display("FAIL speed_t1 got %0d want 696", r0[0]); end
        repeat (4) cyc();
        n_vec += 2;
        if (r0[0] !== 11'd692) begin n_err++; $display("FAIL speed_t2 got %0d want 692", r0[0]); end
        if (r0[3] !== 11'd1172) begin n_err++; $display("FAIL speed_r3 got %0d want 1172", r0[3]); end
    endtask

    task automatic test_async_reset();
        repeat (692) cyc();
        n_vec += 3;
        if (pw0 !== 1'b1) begin n_err++; $display("FAIL fast_wrap got %b want 1", pw0); end
        if (r0[0] !== 11'd640) begin n_err++; $display("FAIL fast_r0 got %0d want 640", r0[0]); end
        if (sc0 !== 4'd1) begin n_err++; $display("FAIL fast_score got %0d want 1", sc0); end
        #3;
        reset = 1'b0;
        mreset(0);
        mreset(1);
        #1;
        n_vec += 5;
        if (pw0 !== 1'b0) begin n_err++; $display("FAIL arst_wrap got %b want 0", pw0); end
        if ({qi0, qc0, qs0} !== 3'b100) begin n_err++; $display("FAIL arst_state got %b want 100", {qi0, qc0, qs0}); end
        if (r0[0] !== 11'd700) begin n_err++; $display("FAIL arst_r0 got %0d want 700", r0[0]); end
        if (r0[3] !== 11'd1180) begin n_err++; $display("FAIL arst_r3 got %0d want 1180", r0[3]); end
        if (sc0 !== 4'd0) begin n_err++; $display("FAIL arst_score got %0d want 0", sc0); end
        cyc();
        reset = 1'b1;
        speed = 2'd0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            speed = 2'($urandom_range(0, 3));
            start = ($urandom_range(0, 19) == 0);
            hit   = ($urandom_range(0, 399) == 0);
            ack   = ($urandom_range(0, 9) == 0);
            cyc();
            n_vec += 4;
            if ({qi0, qc0, qs0} !== {m_mode[0] == 0, m_mode[0] == 1, m_mode[0] == 2}) begin
                n_err++;
                $display("FAIL rnd_state cyc %0d got %b want mode %0d", n, {qi0, qc0, qs0}, m_mode[0]);
            end
            if (sc0 !== 4'(m_score[0])) begin
                n_err++;
                $display("FAIL rnd_score cyc %0d got %0d want %0d", n, sc0, m_score[0]);
            end
            if (pw0 !== m_wrap[0]) begin
                n_err++;
                $display("FAIL rnd_wrap cyc %0d got %b want %b", n, pw0, m_wrap[0]);
            end
            if (op0 !== 2'(m_op[0])) begin
                n_err++;
                $display("FAIL rnd_op cyc %0d got %0d want %0d", n, op0, m_op[0]);
            end
            for (int i = 0; i < 4; i++) begin
                n_vec += 2;
                if (r0[i] !== 11'(m_r[0][i])) begin
                    n_err++;
                    $display("FAIL rnd_r%0d cyc %0d got %0d want %0d", i, n, r0[i], m_r[0][i]);
                end
                if (l0[i] !== 11'((m_r[0][i] >= 60) ? m_r[0][i] - 60 : 0)) begin
                    n_err++;
                    $display("FAIL rnd_l%0d cyc %0d got %0d want r-60 of %0d", i, n, l0[i], m_r[0][i]);
                end
            end
        end
        start = 1'b0;
        hit = 1'b0;
        ack = 1'b0;
        speed = 2'd0;
    endtask

    task automatic test_saturate();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        start2 = 1'b1;
        cyc();
        start2 = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            speed2 = 2'($urandom_range(0, 1));
            cyc();
            n_vec += 3;
            if (sc1 !== 4'(m_score[1])) begin
                n_err++;
                $display("FAIL sat_score cyc %0d got %0d want %0d", n, sc1, m_score[1]);
            end
            if ({pw1, op1} !== {m_wrap[1], 2'(m_op[1])}) begin
                n_err++;
                $display("FAIL sat_wrap cyc %0d got %b want %b/%0d", n, {pw1, op1}, m_wrap[1], m_op[1]);
            end
            if (l1[0] !== 11'((m_r[1][0] >= 20) ? m_r[1][0] - 20 : 0)) begin
                n_err++;
                $display("FAIL sat_l0 cyc %0d got %0d want r-20 of %0d", n, l1[0], m_r[1][0]);
            end
            for (int i = 0; i < 4; i++) begin
                n_vec++;
                if (r1[i] !== 11'(m_r[1][i])) begin
                    n_err++;
                    $display("FAIL sat_r%0d cyc %0d got %0d want %0d", i, n, r1[i], m_r[1][i]);
                end
            end
        end
        n_vec++;
        if (sc1 !== 4'd15) begin n_err++; $display("FAIL sat_final got %0d want 15", sc1); end
    endtask

    initial begin
        reset = 1'b0;
        {start, ack, hit, speed} = '0;
        {start2, ack2, hit2, speed2} = '0;
        test_reset();
        test_scroll();
        test_score();
        test_hit();
        test_speed();
        test_async_reset();
        test_random();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
